alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 126 ++++++++++++
 tb/tb_alu_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - request/response sequencer that drives an external ALU and captures its result
module alu_seq #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [5:0]  REQ_OPRN,
  input  logic [31:0] REQ_OP1,
  input  logic [31:0] REQ_OP2,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_DATA,
  output logic        RSP_ZERO,
  output logic        RSP_ERR,
  output logic [31:0] ALU_OP1,
  output logic [31:0] ALU_OP2,
  output logic [5:0]  ALU_OPRN,
  input  logic [31:0] ALU_OUT,
  input  logic        ALU_ZERO,
  output logic [15:0] OP_COUNT
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        legal;
  logic        accept;
  logic        capture;
  logic        retire;

  assign legal     = (REQ_OPRN >= 6'h01) && (REQ_OPRN <= 6'h09);
  assign REQ_READY = (state == IDLE);
  assign accept    = (state == IDLE) && REQ_VALID;
  assign capture   = (state == EXEC) && (cnt == 4'd0);
  assign retire    = (state == RESP) && RSP_READY;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (REQ_VALID) begin
          state_nxt = legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Settle counter: loaded on a legal accept, counts down while the ALU inputs settle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= 4'd0;
    end else if (accept && legal) begin
      cnt <= SETTLE_LOAD;
    end else if ((state == EXEC) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // ALU operands only move on a legal accept, so illegal requests leave them untouched
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALU_OP1  <= 32'd0;
      ALU_OP2  <= 32'd0;
      ALU_OPRN <= 6'd0;
    end else if (accept && legal) begin
      ALU_OP1  <= REQ_OP1;
      ALU_OP2  <= REQ_OP2;
      ALU_OPRN <= REQ_OPRN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RSP_VALID <= 1'b0;
      RSP_DATA  <= 32'd0;
      RSP_ZERO  <= 1'b0;
      RSP_ERR   <= 1'b0;
    end else if (accept && !legal) begin
      RSP_VALID <= 1'b1;
      RSP_DATA  <= 32'd0;
      RSP_ZERO  <= 1'b0;
      RSP_ERR   <= 1'b1;
    end else if (capture) begin
      RSP_VALID <= 1'b1;
      RSP_DATA  <= ALU_OUT;
      RSP_ZERO  <= ALU_ZERO;
      RSP_ERR   <= 1'b0;
    end else if (retire) begin
      RSP_VALID <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OP_COUNT <= 16'd0;
    end else if (retire && !RSP_ERR) begin
      OP_COUNT <= OP_COUNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with a behavioural ALU model
module tb_alu_seq;

  typedef struct {
    logic [31:0] d;
    logic        z;
    logic        e;
    int          lat;
  } exp_t;

  logic        CLK;
  logic        RST;
  logic        rr;
  logic [5:0]  oprn;
  logic [31:0] op1, op2;
  logic        v2, v1, v15;

  logic        rdy2, rv2, rz2, re2, az2;
  logic [31:0] rd2, a1_2, a2_2, ao2;
  logic [5:0]  ao_2;
  logic [15:0] cnt2;

  logic        rdy1, rv1, rz1, re1, az1;
  logic [31:0] rd1, a1_1, a2_1, ao1;
  logic [5:0]  ao_1;
  logic [15:0] cnt1;

  logic        rdy15, rv15, rz15, re15, az15;
  logic [31:0] rd15, a1_15, a2_15, ao15;
  logic [5:0]  ao_15;
  logic [15:0] cnt15;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t sb[$];

  function automatic logic [31:0] alu_f(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      6'h01: return a + b;
      6'h02: return a - b;
      6'h03: return a * b;
      6'h04: return a >> b[4:0];
      6'h05: return a << b[4:0];
      6'h06: return a & b;
      6'h07: return a | b;
      6'h08: return ~(a | b);
      6'h09: return {31'd0, $signed(a) < $signed(b)};
      default: return 32'd0;
    endcase
  endfunction

  assign ao2  = alu_f(ao_2, a1_2, a2_2);
  assign az2  = (ao2 == 32'd0);
  assign ao1  = alu_f(ao_1, a1_1, a2_1);
  assign az1  = (ao1 == 32'd0);
  assign ao15 = alu_f(ao_15, a1_15, a2_15);
  assign az15 = (ao15 == 32'd0);

  alu_seq #(.SETTLE_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(v2), .REQ_READY(rdy2), .REQ_OPRN(oprn),
    .REQ_OP1(op1), .REQ_OP2(op2), .RSP_VALID(rv2), .RSP_READY(rr), .RSP_DATA(rd2),
    .RSP_ZERO(rz2), .RSP_ERR(re2), .ALU_OP1(a1_2), .ALU_OP2(a2_2), .ALU_OPRN(ao_2),
    .ALU_OUT(ao2), .ALU_ZERO(az2), .OP_COUNT(cnt2)
  );

  alu_seq #(.SETTLE_CYCLES(1)) dut_s1 (
    .CLK(CLK), .RST(RST), .REQ_VALID(v1), .REQ_READY(rdy1), .REQ_OPRN(oprn),
    .REQ_OP1(op1), .REQ_OP2(op2), .RSP_VALID(rv1), .RSP_READY(1'b1), .RSP_DATA(rd1),
    .RSP_ZERO(rz1), .RSP_ERR(re1), .ALU_OP1(a1_1), .ALU_OP2(a2_1), .ALU_OPRN(ao_1),
    .ALU_OUT(ao1), .ALU_ZERO(az1), .OP_COUNT(cnt1)
  );

  alu_seq #(.SETTLE_CYCLES(15)) dut_s15 (
    .CLK(CLK), .RST(RST), .REQ_VALID(v15), .REQ_READY(rdy15), .REQ_OPRN(oprn),
    .REQ_OP1(op1), .REQ_OP2(op2), .RSP_VALID(rv15), .RSP_READY(1'b1), .RSP_DATA(rd15),
    .RSP_ZERO(rz15), .RSP_ERR(re15), .ALU_OP1(a1_15), .ALU_OP2(a2_15), .ALU_OPRN(ao_15),
    .ALU_OUT(ao15), .ALU_ZERO(az15), .OP_COUNT(cnt15)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Drive one request on the main DUT and wait for its accept edge
  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic ez, input logic ee, input int el,
                       input bit want_rsp);
    exp_t e;
    int n;
    @(negedge CLK);
    oprn = o; op1 = a; op2 = b; v2 = 1'b1;
    if (want_rsp) begin
      e.d = ed; e.z = ez; e.e = ee; e.lat = el;
      sb.push_back(e);
    end
    n = 0;
    while (!rdy2 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1 acc_cyc = cyc;
    @(negedge CLK);
    v2 = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(rv2 && rr) && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 40) chk("rsp_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pops an expectation on each new response and checks it holds until retired
  initial begin
    exp_t cur;
    logic pv;
    pv = 1'b0;
    cur.d = '0; cur.z = 1'b0; cur.e = 1'b0; cur.lat = 0;
    forever begin
      @(negedge CLK);
      if (RST && rv2) begin
        if (!pv) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            cur = sb.pop_front();
            chk("rsp_data", rd2, cur.d);
            chk("rsp_zero", {31'd0, rz2}, {31'd0, cur.z});
            chk("rsp_err", {31'd0, re2}, {31'd0, cur.e});
            chk("latency", 32'(cyc - acc_cyc), 32'(cur.lat));
          end
        end else begin
          chk("hold_data", rd2, cur.d);
          chk("hold_zero_err", {30'd0, rz2, re2}, {30'd0, cur.z, cur.e});
        end
      end
      pv = RST && rv2;
    end
  end

  initial begin
    int l1, l15, t0;
    logic [31:0] d1, d15;
    RST = 1'b1; rr = 1'b1; v2 = 1'b0; v1 = 1'b0; v15 = 1'b0;
    oprn = 6'd0; op1 = 32'd0; op2 = 32'd0;
    #3 RST = 1'b0;
    #4;
    chk("reset_ready", {31'd0, rdy2}, 32'd1);
    chk("reset_valid", {31'd0, rv2}, 32'd0);
    chk("reset_count", {16'd0, cnt2}, 32'd0);
    chk("reset_alu_oprn", {26'd0, ao_2}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    issue(6'h01, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 2, 1'b1);
    wait_done();
    chk("count_after_add", {16'd0, cnt2}, 32'd1);

    issue(6'h02, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 2, 1'b1);
    wait_done();
    chk("count_after_sub", {16'd0, cnt2}, 32'd2);

    // An error response is raised by the accept edge itself
    issue(6'h0A, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 0, 1'b1);
    wait_done();
    chk("illegal_alu_op1", a1_2, 32'd9);
    chk("illegal_alu_op2", a2_2, 32'd9);
    chk("illegal_alu_oprn", {26'd0, ao_2}, 32'd2);
    chk("count_after_illegal", {16'd0, cnt2}, 32'd2);
    chk("retained_err", {31'd0, re2}, 32'd1);

    @(negedge CLK);
    rr = 1'b0;
    issue(6'h06, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 2, 1'b1);
    oprn = 6'h07; op1 = 32'd1; op2 = 32'd2; v2 = 1'b1;
    begin
      exp_t e;
      e.d = 32'd3; e.z = 1'b0; e.e = 1'b0; e.lat = 2;
      sb.push_back(e);
    end
    t0 = 0;
    while (!rv2 && t0 < 20) begin
      @(negedge CLK);
      t0++;
    end
    if (t0 >= 20) chk("bp_rsp_timeout", 32'd0, 32'd1);
    repeat (5) begin
      @(negedge CLK);
      chk("bp_ready_low", {31'd0, rdy2}, 32'd0);
      chk("bp_no_accept", {26'd0, ao_2}, 32'd6);
    end
    rr = 1'b1;
    @(posedge CLK);
    #1;
    chk("bp_retire_valid", {31'd0, rv2}, 32'd0);
    chk("bp_retire_oprn", {26'd0, ao_2}, 32'd6);
    @(posedge CLK);
    #1 acc_cyc = cyc;
    chk("bp_second_accept", {26'd0, ao_2}, 32'd7);
    @(negedge CLK);
    v2 = 1'b0;
    wait_done();
    chk("count_after_bp", {16'd0, cnt2}, 32'd4);

    issue(6'h03, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 2, 1'b0);
    #2 RST = 1'b0;
    #1;
    chk("rst_valid", {31'd0, rv2}, 32'd0);
    chk("rst_data", rd2, 32'd0);
    chk("rst_alu_op1", a1_2, 32'd0);
    chk("rst_alu_oprn", {26'd0, ao_2}, 32'd0);
    chk("rst_count", {16'd0, cnt2}, 32'd0);
    chk("rst_ready", {31'd0, rdy2}, 32'd1);
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1 RST = 1'b1;
    issue(6'h09, 32'd3, 32'd4, 32'd1, 1'b0, 1'b0, 2, 1'b1);
    wait_done();
    chk("count_after_slt", {16'd0, cnt2}, 32'd1);

    @(negedge CLK);
    oprn = 6'h01; op1 = 32'd100; op2 = 32'd23; v1 = 1'b1; v15 = 1'b1;
    @(posedge CLK);
    #1 t0 = cyc;
    @(negedge CLK);
    v1 = 1'b0; v15 = 1'b0;
    l1 = -1; l15 = -1; d1 = '0; d15 = '0;
    for (int i = 0; i < 25; i++) begin
      if (rv1 && l1 < 0) begin l1 = cyc - t0; d1 = rd1; end
      if (rv15 && l15 < 0) begin l15 = cyc - t0; d15 = rd15; end
      @(negedge CLK);
    end
    chk("latency_s1", 32'(l1), 32'd1);
    chk("latency_s15", 32'(l15), 32'd15);
    chk("data_s1", d1, 32'd123);
    chk("data_s15", d15, 32'd123);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
